display_7seg_scanner: RTL and testbench
=======================================

Name: display_7seg_scanner

Overview:
Multiplexed multi-digit 7-segment display driver for the SAP-1 front panel. It latches a packed hex value plus per-digit decimal points and time-multiplexes them onto one shared segment bus and a digit-select bus. The block adds a refresh prescaler, a guard (anti-ghost) interval, frame-synchronous update, leading-zero blanking and selectable output polarity to the existing single-digit hex decode.

Parameters:
DIGITS, 4, number of digits (>=1); digit 0 least significant.
CLK_DIV, 1000, clock cycles per digit slot (must be > GUARD).
GUARD, 2, cycles at the start of each slot with all outputs off (>=0).
ACTIVE_LOW_SEG, 0, 1 = segment outputs active-low.
ACTIVE_LOW_DIG, 1, 1 = digit selects active-low.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
load  input  1  capture value/dp_in at this clock edge.
value  input  4*DIGITS  packed nibbles; nibble k = digit k.
dp_in  input  DIGITS  decimal point per digit.
blank_lz  input  1  1 = blank leading zeros.
seg_out  output  8  bit0=a ... bit6=g, bit7=dp.
dig_sel  output  DIGITS  one-hot digit enable (polarity per ACTIVE_LOW_DIG).
frame_done  output  1  one-cycle pulse at end of each full scan.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high. Every register clears on reset assertion without a clock edge.
- Reset values: seg_out = all segments off (8'h00, or 8'hFF if ACTIVE_LOW_SEG), dig_sel = all inactive, frame_done = 0, prescaler cnt = 0, digit index idx = 0, displayed and pending registers = 0, pending flag = 0.
- Prescaler: cnt counts 0..CLK_DIV-1 and wraps. When cnt == CLK_DIV-1, idx advances. idx wraps from DIGITS-1 to 0.
- Frame boundary: this is the cycle where cnt == CLK_DIV-1 and idx == DIGITS-1.
  - frame_done is registered and is high for exactly the one cycle after that edge.
  - If the pending flag is set, the pending value and dp are copied to the displayed registers at that edge, and the flag clears.
- Load: load = 1 writes value/dp_in into the pending registers and sets the pending flag.
  - Several loads within one frame: the last one wins.
  - A load on the boundary cycle itself goes to pending and is committed at the next boundary.
  - The displayed data never changes mid-frame (no tearing).
- Slot output:
  - When cnt < GUARD, the slot is in guard: all segments off and all digits inactive.
  - Otherwise dig_sel enables digit idx only, and seg_out = decode(displayed nibble idx), with bit7 = dp of that digit.
- Decode table (active-high, before polarity), hex digits 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Leading-zero blanking: with blank_lz = 1, digit k (k > 0) is blanked when nibbles k..DIGITS-1 are all zero.
  - A blanked digit has segments a-g off, but its dp still follows dp_in.
  - Digit 0 is never blanked.
  - blank_lz is sampled live, not latched.
- Polarity: applied last, as an XOR with ACTIVE_LOW_SEG and ACTIVE_LOW_DIG.
- Latency: seg_out and dig_sel are registered. The output for state (idx, cnt) at edge n appears after edge n+1, so each slot pattern is shifted by one cycle relative to cnt.
- Frame length: exactly DIGITS*CLK_DIV cycles.
- Reset mid-frame: outputs go off immediately. Scanning restarts at idx 0, cnt 0 after release, with 0 displayed and nothing pending.

Decomposition:
- Shared package seg7_pkg holds:
  - segment bit-index constants (SEG_A..SEG_G, SEG_DP);
  - the 16-entry hex-to-segment constant table;
  - the SEG_OFF constant.
- One sub-module, seg7_hex_decode: purely combinational, 4-bit nibble + blank + dp -> 8-bit active-high pattern.
- The scanner instantiates it once, on the muxed nibble.

Test Plan:
All scenarios use DIGITS=4, CLK_DIV=8, GUARD=2, ACTIVE_LOW_DIG=1, ACTIVE_LOW_SEG=0.
1. Reset, load value=16'h12AF, dp_in=0, wait one boundary -> next frame:
   - slot 0: seg_out=8'h71, dig_sel=4'b1110;
   - slot 1: 8'h77;
   - slot 2: 8'h5B;
   - slot 3: 8'h06, dig_sel=4'b0111.
2. blank_lz=1 with value=16'h0050 -> slots 3 and 2 seg_out=8'h00, slot 1 8'h6D, slot 0 8'h3F. With value=0, only slot 0 shows 8'h3F.
3. Steady scan:
   - the first 2 output cycles of each slot show dig_sel=4'b1111 and seg_out=8'h00;
   - frame_done pulses once every 32 cycles, each pulse 1 cycle wide.
4. Mid-frame load of 16'h1111 followed by 16'h2222 before the boundary -> the current frame still shows old data; the next frame shows all slots 8'h5B; no frame ever shows 8'h06.
5. Assert reset asynchronously mid-slot (between clock edges) -> seg_out=8'h00 and dig_sel=4'b1111 immediately. After release, the first active slot is digit 0 showing 8'h3F.
6. ACTIVE_LOW_SEG=1, value nibble 8, dp set -> active slot seg_out=8'h00; guard cycles seg_out=8'hFF.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, the hex glyph table
// and the all-off pattern, all in active-high form.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Entry 15 is leftmost, so HEX_SEG[n] is the glyph for hex digit n.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to 7-segment decode, active-high. Blanking turns
// off segments a-g only; the decimal point always follows dp.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    if (!blank) begin
      pattern[SEG_G:SEG_A] = HEX_SEG[nibble][SEG_G:SEG_A];
    end
    pattern[SEG_DP] = dp;
  end

endmodule

// File: rtl/display_7seg_scanner.sv
// Multiplexed multi-digit 7-segment scanner: refresh prescaler, guard interval,
// frame-synchronous value update, leading-zero blanking and output polarity.
module display_7seg_scanner
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter int GUARD          = 2,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_DIG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [7:0]        SEG_POL = (ACTIVE_LOW_SEG != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_POL = (ACTIVE_LOW_DIG != 0) ? '1 : '0;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                slot_end;
  logic                last_digit;
  logic                boundary;
  logic                in_guard;

  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_flag;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;

  logic [DIGITS-1:0]   zero_hi;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic [7:0]          pattern;
  logic [DIGITS-1:0]   dig_onehot;

  logic [7:0]          seg_p1;
  logic [DIGITS-1:0]   dig_p1;
  logic                fd_p1;

  assign slot_end   = (cnt == CNT_W'(CLK_DIV - 1));
  assign last_digit = (idx == IDX_W'(DIGITS - 1));
  assign boundary   = slot_end && last_digit;
  assign in_guard   = (int'(cnt) < GUARD);

  // Stage p0: prescaler and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= last_digit ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load on the boundary edge lands in pending after the old pending commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_val  <= '0;
      disp_dp   <= '0;
    end else begin
      if (boundary && pend_flag) begin
        disp_val  <= pend_val;
        disp_dp   <= pend_dp;
        pend_flag <= 1'b0;
      end
      if (load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end
    end
  end

  // zero_hi[k] is set when nibbles k..DIGITS-1 are all zero.
  always_comb begin
    zero_hi  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (disp_val[4*k +: 4] == 4'h0);
      zero_hi[k] = zero_run;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(idx) == k) begin
        cur_nib = disp_val[4*k +: 4];
        cur_dp  = disp_dp[k];
        cur_lz  = (k != 0) && zero_hi[k];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble  (cur_nib),
    .blank   (blank_lz && cur_lz),
    .dp      (cur_dp),
    .pattern (pattern)
  );

  assign dig_onehot = DIGITS'(1) << idx;

  // Stage p1: registered outputs with polarity applied
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_p1 <= SEG_OFF ^ SEG_POL;
      dig_p1 <= DIG_POL;
      fd_p1  <= 1'b0;
    end else begin
      fd_p1 <= boundary;
      if (in_guard) begin
        seg_p1 <= SEG_OFF ^ SEG_POL;
        dig_p1 <= DIG_POL;
      end else begin
        seg_p1 <= pattern ^ SEG_POL;
        dig_p1 <= dig_onehot ^ DIG_POL;
      end
    end
  end

  assign seg_out    = seg_p1;
  assign dig_sel    = dig_p1;
  assign frame_done = fd_p1;

endmodule

// File: tb/tb_display_7seg_scanner.sv
// Randomized bench for display_7seg_scanner with a cycle-level reference model
// derived from elapsed cycles since reset; a second instance uses active-low segments.
module tb_display_7seg_scanner;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;
  logic [7:0]  seg_al;
  logic [3:0]  dig_al;
  logic        fd_al;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  int          m_n;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_flag;

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  display_7seg_scanner #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GUARD(GUARD),
    .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_DIG(1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  display_7seg_scanner #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GUARD(GUARD),
    .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1)
  ) dut_al (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg_out(seg_al), .dig_sel(dig_al), .frame_done(fd_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at model cycle %0d: got %0h expected %0h", tag, m_n, got, exp);
    end
  endtask

  task automatic model_clear();
    m_n    = 0;
    m_disp = '0;
    m_pend = '0;
    m_dp   = '0;
    m_pdp  = '0;
    m_flag = 1'b0;
  endtask

  // One clock: predict the outputs registered at this edge, advance the model, compare.
  task automatic tick();
    int         cnt, idx;
    logic [7:0] es;
    logic [3:0] ed;
    logic       ef;
    logic       blank;
    cnt = m_n % CLK_DIV;
    idx = (m_n / CLK_DIV) % DIGITS;
    ef  = (m_n % FRAME) == FRAME - 1;
    if (cnt < GUARD) begin
      es = 8'h00;
      ed = 4'hF;
    end else begin
      blank = blank_lz && idx > 0 && ((m_disp >> (4 * idx)) == 16'h0);
      es    = blank ? 8'h00 : glyph[m_disp[4*idx +: 4]];
      es[7] = m_dp[idx];
      ed    = ~(4'b0001 << idx);
    end
    if (ef && m_flag) begin
      m_disp = m_pend;
      m_dp   = m_pdp;
      m_flag = 1'b0;
    end
    if (load) begin
      m_pend = value;
      m_pdp  = dp_in;
      m_flag = 1'b1;
    end
    m_n++;
    @(posedge clk);
    #1;
    chk("seg_out", 32'(seg_out), 32'(es));
    chk("dig_sel", 32'(dig_sel), 32'(ed));
    chk("frame_done", 32'(frame_done), 32'(ef));
    chk("seg_out_al", 32'(seg_al), 32'(es ^ 8'hFF));
    chk("dig_sel_al", 32'(dig_al), 32'(ed));
    if (frame_done) fd_count++;
  endtask

  task automatic run_to(input int target);
    while (m_n <= target) tick();
  endtask

  task automatic load_tick(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_seg", 32'(seg_out), 32'h00);
    chk("rst_dig", 32'(dig_sel), 32'hF);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_seg_al", 32'(seg_al), 32'hFF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    blank_lz = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("init_seg", 32'(seg_out), 32'h00);
    chk("init_dig", 32'(dig_sel), 32'hF);
    chk("init_fd", 32'(frame_done), 32'h0);
    chk("init_seg_al", 32'(seg_al), 32'hFF);
    reset = 1'b0;

    // Basic decode, visible from the frame after the load.
    load_tick(16'h12AF, 4'h0);
    run_to(34); chk("s1_slot0", 32'(seg_out), 32'h71); chk("s1_dig0", 32'(dig_sel), 32'hE);
    run_to(42); chk("s1_slot1", 32'(seg_out), 32'h77);
    run_to(50); chk("s1_slot2", 32'(seg_out), 32'h5B);
    run_to(58); chk("s1_slot3", 32'(seg_out), 32'h06); chk("s1_dig3", 32'(dig_sel), 32'h7);

    // Frame pulse rate and guard cycles.
    fd_count = 0;
    repeat (3 * FRAME) tick();
    chk("fd_count", 32'(fd_count), 32'd3);
    run_to(160); chk("guard0_seg", 32'(seg_out), 32'h00); chk("guard0_dig", 32'(dig_sel), 32'hF);
    run_to(161); chk("guard1_seg", 32'(seg_out), 32'h00); chk("guard1_dig", 32'(dig_sel), 32'hF);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_tick(16'h0050, 4'h0);
    run_to(194); chk("lz_slot0", 32'(seg_out), 32'h3F);
    run_to(202); chk("lz_slot1", 32'(seg_out), 32'h6D);
    run_to(210); chk("lz_slot2", 32'(seg_out), 32'h00);
    run_to(218); chk("lz_slot3", 32'(seg_out), 32'h00);
    load_tick(16'h0000, 4'h0);
    run_to(226); chk("lz0_slot0", 32'(seg_out), 32'h3F);
    run_to(234); chk("lz0_slot1", 32'(seg_out), 32'h00);
    run_to(255);
    blank_lz = 1'b0;

    // Two loads inside one frame: old data stays, then the last load wins.
    run_to(259);
    load_tick(16'h1111, 4'h0);
    run_to(269);
    load_tick(16'h2222, 4'h0);
    run_to(282); chk("tear_old", 32'(seg_out), 32'h3F);
    run_to(290); chk("tear_new0", 32'(seg_out), 32'h5B);
    run_to(314); chk("tear_new3", 32'(seg_out), 32'h5B);

    // Asynchronous reset mid-slot.
    run_to(323);
    do_reset();
    run_to(2); chk("post_rst_seg", 32'(seg_out), 32'h3F); chk("post_rst_dig", 32'(dig_sel), 32'hE);

    // Active-low segments: 8 with dp lights everything.
    load_tick(16'h8888, 4'hF);
    run_to(34); chk("al_active", 32'(seg_al), 32'h00); chk("ah_active", 32'(seg_out), 32'hFF);
    run_to(40); chk("al_guard", 32'(seg_al), 32'hFF); chk("ah_guard", 32'(seg_out), 32'h00);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        dp_in = 4'($urandom);
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
